// File: rtl/ram_2port_arb_if.sv
// Request/response bundle between two requesters, the arbiter and a
// simple dual-port RAM (one write port, one read port).
//
// Handshake: a requester raises reqN_i with weN_i/addrN_i/wdataN_i stable
// and keeps them stable until gntN_o is seen high in the same cycle; that
// cycle is the transfer (req acts as valid, gnt as ready). reqN_i may be
// raised again in the very next cycle for a new operation. Read data comes
// back later as a one-cycle rvalidN_o pulse with rdataN_o; there is no
// backpressure on the return path.
interface ram_2port_arb_if #(
  parameter int AW = 8,
  parameter int DW = 32
);

  // requester 0
  logic          req0_i;
  logic          we0_i;
  logic [AW-1:0] addr0_i;
  logic [DW-1:0] wdata0_i;
  logic          gnt0_o;
  logic          rvalid0_o;
  logic [DW-1:0] rdata0_o;

  // requester 1
  logic          req1_i;
  logic          we1_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata1_i;
  logic          gnt1_o;
  logic          rvalid1_o;
  logic [DW-1:0] rdata1_o;

  // RAM write port
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [DW-1:0] ram_wr_data_o;

  // RAM read port
  logic          ram_rd_en_o;
  logic [AW-1:0] ram_rd_addr_o;
  logic [DW-1:0] ram_rd_data_i;

  // requesters and RAM side (the environment around the arbiter)
  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    input  gnt0_o, rvalid0_o, rdata0_o,
    input  gnt1_o, rvalid1_o, rdata1_o,
    input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o,
    input  ram_rd_en_o, ram_rd_addr_o,
    output ram_rd_data_i
  );

  // the arbiter itself
  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    output gnt0_o, rvalid0_o, rdata0_o,
    output gnt1_o, rvalid1_o, rdata1_o,
    output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o,
    output ram_rd_en_o, ram_rd_addr_o,
    input  ram_rd_data_i
  );

endinterface

// File: rtl/ram_2port_arb.sv
// Two-requester arbiter in front of a dual-port RAM.
//
// Writes and reads are arbitrated separately, each with its own
// round-robin pointer holding the id of the last requester granted on that
// port, so one write and one read can be accepted in the same cycle.
// Accepted operations are issued to the RAM one cycle later through
// registered strobes. Reads are followed by a two-stage (valid, id) tag
// pipeline that routes the RAM data back to the requester that asked.
//
// Read-after-write hazard: a read that targets the address being written
// in the same cycle is held off for one cycle, so it is issued after the
// write has landed and returns the new data.
module ram_2port_arb #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input logic clk_i,
  input logic rst_i,
  ram_2port_arb_if.slave bus
);

  // ---------------------------------------------------------------------
  // Round-robin pointers (id of the last granted requester per port)
  // ---------------------------------------------------------------------
  logic w_last;
  logic r_last;

  // ---------------------------------------------------------------------
  // Write arbitration signals
  // ---------------------------------------------------------------------
  logic          w_cand0;
  logic          w_cand1;
  logic          w_go0;
  logic          w_go1;
  logic          w_any;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  // ---------------------------------------------------------------------
  // Read arbitration signals
  // ---------------------------------------------------------------------
  logic          r_cand0;
  logic          r_cand1;
  logic          r_go0;
  logic          r_go1;
  logic          r_any;
  logic          r_id;
  logic [AW-1:0] r_addr;

  // ---------------------------------------------------------------------
  // Read tag pipeline: stage 1 lines up with ram_rd_en_o, stage 2 with the
  // cycle in which ram_rd_data_i is valid.
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic s1_id;
  logic s2_valid;
  logic s2_id;

  // Write arbitration: requester that was not last granted wins a tie.
  always_comb begin
    w_cand0 = bus.req0_i & bus.we0_i;
    w_cand1 = bus.req1_i & bus.we1_i;
    w_go0   = 1'b0;
    w_go1   = 1'b0;
    if (!rst_i) begin
      if (w_cand0 && w_cand1) begin
        w_go0 = (w_last == 1'b1);
        w_go1 = (w_last == 1'b0);
      end else begin
        w_go0 = w_cand0;
        w_go1 = w_cand1;
      end
    end
    w_any  = w_go0 | w_go1;
    w_addr = w_go1 ? bus.addr1_i  : bus.addr0_i;
    w_data = w_go1 ? bus.wdata1_i : bus.wdata0_i;
  end

  // Read arbitration: candidates colliding with this cycle's write are
  // removed before the round-robin choice, so they retry next cycle.
  always_comb begin
    r_cand0 = bus.req0_i & ~bus.we0_i;
    r_cand1 = bus.req1_i & ~bus.we1_i;
    if (w_any && (bus.addr0_i == w_addr)) begin
      r_cand0 = 1'b0;
    end
    if (w_any && (bus.addr1_i == w_addr)) begin
      r_cand1 = 1'b0;
    end
    r_go0 = 1'b0;
    r_go1 = 1'b0;
    if (!rst_i) begin
      if (r_cand0 && r_cand1) begin
        r_go0 = (r_last == 1'b1);
        r_go1 = (r_last == 1'b0);
      end else begin
        r_go0 = r_cand0;
        r_go1 = r_cand1;
      end
    end
    r_any  = r_go0 | r_go1;
    r_id   = r_go1;
    r_addr = r_go1 ? bus.addr1_i : bus.addr0_i;
  end

  // A requester carries one op per cycle, so at most one of its write or
  // read grants can be high.
  assign bus.gnt0_o = w_go0 | r_go0;
  assign bus.gnt1_o = w_go1 | r_go1;

  // Round-robin pointers move only when their port grants.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_last <= 1'b1;
      r_last <= 1'b1;
    end else begin
      if (w_any) begin
        w_last <= w_go1;
      end
      if (r_any) begin
        r_last <= r_id;
      end
    end
  end

  // Write port issue: strobe for one cycle, address/data from the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ram_wr_en_o   <= 1'b0;
      bus.ram_wr_addr_o <= '0;
      bus.ram_wr_data_o <= '0;
    end else begin
      bus.ram_wr_en_o <= w_any;
      if (w_any) begin
        bus.ram_wr_addr_o <= w_addr;
        bus.ram_wr_data_o <= w_data;
      end
    end
  end

  // Read port issue plus first tag stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.ram_rd_en_o   <= 1'b0;
      bus.ram_rd_addr_o <= '0;
      s1_valid          <= 1'b0;
      s1_id             <= 1'b0;
    end else begin
      bus.ram_rd_en_o <= r_any;
      s1_valid        <= r_any;
      if (r_any) begin
        bus.ram_rd_addr_o <= r_addr;
        s1_id             <= r_id;
      end
    end
  end

  // Second tag stage: valid while the RAM presents the read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  // Return path: capture RAM data into the owner's register and pulse rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rvalid0_o <= 1'b0;
      bus.rvalid1_o <= 1'b0;
      bus.rdata0_o  <= '0;
      bus.rdata1_o  <= '0;
    end else begin
      bus.rvalid0_o <= s2_valid & ~s2_id;
      bus.rvalid1_o <= s2_valid &  s2_id;
      if (s2_valid && !s2_id) begin
        bus.rdata0_o <= bus.ram_rd_data_i;
      end
      if (s2_valid && s2_id) begin
        bus.rdata1_o <= bus.ram_rd_data_i;
      end
    end
  end

endmodule

// File: doc/ram_2port_arb.md
RAM_2PORT_ARB -- requirements
Module: ram_2port_arb

Interface
REQ-001 Parameters SHALL be: AW, default 8, address width; DW, default 32, data width.
REQ-002 clk_i  in  1  single clock; all logic SHALL be on the rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 req0_i/req1_i  in  1  request from requester n; held high until gnt.
REQ-005 we0_i/we1_i  in  1  request type: 1 = write, 0 = read.
REQ-006 addr0_i/addr1_i  in  AW  request address.
REQ-007 wdata0_i/wdata1_i  in  DW  write data.
REQ-008 gnt0_o/gnt1_o  out  1  combinational grant; the request is accepted this cycle.
REQ-009 rvalid0_o/rvalid1_o  out  1  one-cycle pulse; rdata is valid.
REQ-010 rdata0_o/rdata1_o  out  DW  registered read data; held until the requester's next read completes.
REQ-011 ram_wr_en_o / ram_wr_addr_o / ram_wr_data_o  out  1/AW/DW  registered RAM write-port strobe, address and data.
REQ-012 ram_rd_en_o / ram_rd_addr_o  out  1/AW  registered RAM read-port strobe and address.
REQ-013 ram_rd_data_i  in  DW  RAM read data, valid in the cycle after ram_rd_en_o is high.
REQ-014 The RAM write and read ports SHALL both be clocked by clk_i.

Function
REQ-015 Writes and reads SHALL be arbitrated independently; one write grant and one read grant may both issue in the same cycle.
REQ-016 Each port SHALL have a round-robin pointer (last-granted id).
- On contention, the requester that is not last-granted SHALL win.
- The pointer SHALL update only on a grant for that port.
REQ-017 A lone requester SHALL be granted in the same cycle t as its request, unless REQ-019 applies.
REQ-018 Issue timing for a grant in cycle t:
- The ram_* strobe SHALL be high in cycle t+1 only, with the address and data captured at t.
- Strobes SHALL be low in every other cycle.
REQ-019 Collision rule: if in cycle t the write grant and a candidate read target the same address, the read SHALL NOT be granted in t.
- The read SHALL become eligible at t+1.
- The read therefore returns post-write data.
REQ-020 Read return:
- A 2-stage tag pipeline (valid, id) SHALL track each read.
- For a read granted at t, rdata<id>_o SHALL be loaded from ram_rd_data_i at the edge ending t+2.
- rvalid<id>_o SHALL be high in cycle t+3 for exactly one cycle.
REQ-021 Back-to-back reads, one per cycle, SHALL be supported with no bubbles; data SHALL return in grant order.
REQ-022 A requester SHALL carry at most one op per cycle. It may re-request in the cycle after its gnt.
REQ-023 Inputs of a requester with req low SHALL be ignored.
REQ-024 Address wrap-around SHALL NOT apply: addresses are passed unmodified. All AW values, including 0 and 2^AW-1, are legal.

Reset
REQ-025 While rst_i is high at a clock edge, all outputs SHALL go to 0 at that edge, including:
- ram_* strobes, addresses and write data
- rvalid and rdata
REQ-026 During reset, gnt0_o/gnt1_o SHALL be 0.
REQ-027 Reset SHALL set both round-robin pointers to 1, so requester 0 wins the first contention.
REQ-028 Reset SHALL clear the tag pipeline. Reads in flight when reset is asserted SHALL NOT produce rvalid.

Verification
REQ-029 Reset: hold rst_i 2 cycles with req0_i=1 -> gnt0_o=0 and all outputs 0; 1st cycle after release -> gnt0_o=1.
REQ-030 Single write: req0 we=1 addr=50 wdata=250 at t -> gnt0_o=1 at t; ram_wr_en_o=1, addr=50, data=250 at t+1 only.
REQ-031 Readback: req0 read addr=50 at t -> ram_rd_en_o=1, addr=50 at t+1; rvalid0_o=1 with rdata0_o=250 at t+3.
REQ-032 Write contention:
- Stimulus: both requesters hold write requests for 4 cycles (addr 100/500 and 200/1000), each re-requesting after its grant.
- Grants: gnt0, gnt1, gnt0, gnt1.
- RAM writes: 100/500, 200/1000, ... on successive cycles.
REQ-033 Collision:
- Stimulus: at t, req0 writes addr 250 data 1250 and req1 reads addr 250.
- Grants: gnt0 at t; gnt1 at t+1.
- Return: rvalid1_o at t+4 with rdata1_o=1250.
REQ-034 Reset mid-read: read granted at t, rst_i=1 at t+1 -> no rvalid in t+2..t+4; rdata 0.
